shift_add_multiplier: RTL

- Iterative unsigned N×N → 2N multiplier using the shift-and-add method, one partial product per clock.
- Sits directly upstream of N_bit_full_adder. It instantiates one adder and feeds it the accumulator and multiplicand each cycle, then registers and shifts the sum/carry it produces.
- Start/done handshake. Operands are captured at start; the result is held until the next completion.

---
 rtl/shift_add_multiplier_pkg.sv | 16 +
 rtl/shift_add_multiplier_adder.sv | 24 ++
 rtl/shift_add_multiplier.sv | 93 +++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared FSM encoding and sizing helpers for the shift-and-add multiplier.
// No logic; latency n/a; no backpressure.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter must hold the value N itself.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// N-bit ripple-carry adder used for one partial-product step per clock.
// Latency: combinational; no backpressure.
module N_bit_full_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned NxN -> 2N shift-and-add multiplier, one partial product per clock.
// Latency: done pulses N+1 edges after start is accepted; start is ignored unless idle (not queued).
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int             CW       = count_width(N);
    localparam logic [CW-1:0]  CNT_INIT = CW'(N);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  m_reg;
    logic [CW-1:0] count;

    logic [N-1:0]  add_b;
    logic [N-1:0]  add_sum;
    logic          add_cout;

    assign add_b = q_reg[0] ? m_reg : '0;

    (* keep_hierarchy = "yes" *)
    N_bit_full_adder #(.N(N)) u_adder (
        .a    (a_reg),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start)          state_nxt = ST_CALC;
            ST_CALC: if (count == CNT_ONE) state_nxt = ST_DONE;
            ST_DONE:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // The bit shifted into the carry position is always zero, so the carry
    // out of the adder lands directly in the MSB of A instead of a C register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_CALC);
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        count <= CNT_INIT;
                    end
                end
                ST_CALC: begin
                    a_reg <= {add_cout, add_sum[N-1:1]};
                    q_reg <= {add_sum[0], q_reg[N-1:1]};
                    count <= count - CNT_ONE;
                end
                ST_DONE: begin
                    product <= {a_reg, q_reg};
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
